// File: rtl/sad_search_ctrl_pkg.sv
// Shared types and constants for the SAD sub-pel search controller:
// FSM states, candidate indices, compare priority order and datapath widths.
package sad_search_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    FLUSH   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int PIX_W     = 8;
  localparam int ROW_PIX   = 8;
  localparam int ROW_W     = PIX_W * ROW_PIX;
  localparam int NUM_CAND  = 5;
  localparam int IDX_W     = 3;
  localparam int ROW_SAD_W = 12;
  localparam int ACC_W     = 15;
  localparam int CNT_W     = 4;

  localparam logic [IDX_W-1:0] CAND_RQ   = 3'd0;
  localparam logic [IDX_W-1:0] CAND_RH   = 3'd1;
  localparam logic [IDX_W-1:0] CAND_FULL = 3'd2;
  localparam logic [IDX_W-1:0] CAND_LH   = 3'd3;
  localparam logic [IDX_W-1:0] CAND_LQ   = 3'd4;

  // Entry 0 is visited first; earlier entries win ties.
  localparam logic [NUM_CAND-1:0][IDX_W-1:0] PRIO_ORDER =
    {CAND_LQ, CAND_RQ, CAND_LH, CAND_RH, CAND_FULL};

  localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(NUM_CAND - 1);

endpackage

// File: rtl/sad_search_ctrl_compute_sad.sv
// Combinational per-row SAD for the five sub-pel candidates over pixels 1..6.
// Predictions use truncating linear interpolation between a pixel and its neighbour.
module compute_sad
  import sad_search_ctrl_pkg::*;
(
  input  logic [ROW_W-1:0]                       filter_row_i,
  input  logic [ROW_W-1:0]                       ref_row_i,
  output logic [NUM_CAND-1:0][ROW_SAD_W-1:0]     sad_o
);

  function automatic logic [PIX_W-1:0] interp_quarter(input logic [PIX_W-1:0] near,
                                                      input logic [PIX_W-1:0] far);
    logic [PIX_W+1:0] sum;
    sum = ({2'b00, near} * 10'd3) + {2'b00, far};
    return sum[PIX_W+1:2];
  endfunction

  function automatic logic [PIX_W-1:0] interp_half(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
    logic [PIX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PIX_W:1];
  endfunction

  function automatic logic [ROW_SAD_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                    input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? ROW_SAD_W'(-d) : ROW_SAD_W'(d);
  endfunction

  // Edge filter pixels have no full neighbourhood and never enter the SAD.
  logic unused_edge_pix;
  assign unused_edge_pix = ^{filter_row_i[PIX_W-1:0], filter_row_i[ROW_W-1 -: PIX_W]};

  always_comb begin
    sad_o = '0;
    for (int p = 1; p <= ROW_PIX - 2; p++) begin
      logic [PIX_W-1:0] f, rl, rc, rr;
      f  = filter_row_i[p*PIX_W +: PIX_W];
      rl = ref_row_i[(p-1)*PIX_W +: PIX_W];
      rc = ref_row_i[p*PIX_W +: PIX_W];
      rr = ref_row_i[(p+1)*PIX_W +: PIX_W];
      sad_o[CAND_RQ]   = sad_o[CAND_RQ]   + abs_diff(f, interp_quarter(rc, rl));
      sad_o[CAND_RH]   = sad_o[CAND_RH]   + abs_diff(f, interp_half(rl, rc));
      sad_o[CAND_FULL] = sad_o[CAND_FULL] + abs_diff(f, rc);
      sad_o[CAND_LH]   = sad_o[CAND_LH]   + abs_diff(f, interp_half(rc, rr));
      sad_o[CAND_LQ]   = sad_o[CAND_LQ]   + abs_diff(f, interp_quarter(rc, rr));
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Block search controller: accumulates five candidate SADs over a block of rows,
// then picks the smallest in priority order and reports it with a done pulse.
module sad_search_ctrl
  import sad_search_ctrl_pkg::*;
#(
  parameter int MAX_ROWS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_rows,
  input  logic                 abort,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [ROW_W-1:0]     filter_row,
  input  logic [ROW_W-1:0]     ref_row,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     best_idx,
  output logic [ACC_W-1:0]     best_sad,
  output logic                 cfg_err
);

  localparam logic [CNT_W-1:0] MAX_ROWS_L = CNT_W'(MAX_ROWS);

  state_e                             state_q;
  logic [CNT_W-1:0]                   num_rows_q;
  logic [CNT_W-1:0]                   row_cnt_q;
  logic [IDX_W-1:0]                   cmp_cnt_q;
  logic [NUM_CAND-1:0][ACC_W-1:0]     acc_q;
  logic [ROW_W-1:0]                   filt_p1_q;
  logic [ROW_W-1:0]                   ref_p1_q;
  logic                               vld_p1_q;
  logic [IDX_W-1:0]                   run_idx_q;
  logic [ACC_W-1:0]                   run_sad_q;
  logic [IDX_W-1:0]                   best_idx_q;
  logic [ACC_W-1:0]                   best_sad_q;
  logic                               busy_q;
  logic                               ready_q;
  logic                               done_q;
  logic                               cfg_err_q;

  logic [NUM_CAND-1:0][ROW_SAD_W-1:0] row_sad;
  logic                               accept;
  logic                               start_ok;
  logic [IDX_W-1:0]                   cand;
  logic [ACC_W-1:0]                   cand_sad;
  logic [IDX_W-1:0]                   nxt_idx_d;
  logic [ACC_W-1:0]                   nxt_sad_d;

  assign accept   = ready_q && row_valid && !abort;
  assign start_ok = (num_rows != '0) && (num_rows <= MAX_ROWS_L);

  // Stage p1 -> accumulate: per-row SADs of the registered row.
  compute_sad u_compute_sad (
    .filter_row_i (filt_p1_q),
    .ref_row_i    (ref_p1_q),
    .sad_o        (row_sad)
  );

  // The first visited candidate seeds the running best; later ones replace it
  // only when strictly smaller.
  always_comb begin
    cand      = PRIO_ORDER[cmp_cnt_q];
    cand_sad  = acc_q[cand];
    nxt_idx_d = run_idx_q;
    nxt_sad_d = run_sad_q;
    if ((cmp_cnt_q == '0) || (cand_sad < run_sad_q)) begin
      nxt_idx_d = cand;
      nxt_sad_d = cand_sad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
      cmp_cnt_q  <= '0;
      acc_q      <= '0;
      filt_p1_q  <= '0;
      ref_p1_q   <= '0;
      vld_p1_q   <= 1'b0;
      run_idx_q  <= CAND_FULL;
      run_sad_q  <= '0;
      best_idx_q <= CAND_FULL;
      best_sad_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // Stage p0 -> p1: capture the accepted row.
      vld_p1_q <= accept;
      if (accept) begin
        filt_p1_q <= filter_row;
        ref_p1_q  <= ref_row;
      end

      if (vld_p1_q) begin
        for (int c = 0; c < NUM_CAND; c++) begin
          acc_q[c] <= acc_q[c] + ACC_W'(row_sad[c]);
        end
      end

      if (abort && (state_q != IDLE)) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        ready_q  <= 1'b0;
        vld_p1_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (start_ok) begin
                num_rows_q <= num_rows;
                row_cnt_q  <= '0;
                acc_q      <= '0;
                state_q    <= ACCUM;
                busy_q     <= 1'b1;
                ready_q    <= 1'b1;
              end else begin
                cfg_err_q  <= 1'b1;
              end
            end
          end
          ACCUM: begin
            if (accept) begin
              row_cnt_q <= row_cnt_q + 1'b1;
              if ((row_cnt_q + 1'b1) == num_rows_q) begin
                state_q <= FLUSH;
                ready_q <= 1'b0;
              end
            end
          end
          FLUSH: begin
            cmp_cnt_q <= '0;
            state_q   <= COMPARE;
          end
          COMPARE: begin
            run_idx_q <= nxt_idx_d;
            run_sad_q <= nxt_sad_d;
            cmp_cnt_q <= cmp_cnt_q + 1'b1;
            if (cmp_cnt_q == LAST_CMP) begin
              best_idx_q <= nxt_idx_d;
              best_sad_q <= nxt_sad_d;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign row_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign best_idx  = best_idx_q;
  assign best_sad  = best_sad_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a per-pixel arithmetic reference model
// and a per-cycle checker on done, cfg_err and the best_* outputs.
module tb_sad_search_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_rows = 4'd0;
  logic        abort = 1'b0;
  logic        row_valid = 1'b0;
  logic        row_ready;
  logic [63:0] filter_row = '0;
  logic [63:0] ref_row = '0;
  logic        busy;
  logic        done;
  logic [2:0]  best_idx;
  logic [14:0] best_sad;
  logic        cfg_err;

  sad_search_ctrl #(.MAX_ROWS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rows   (num_rows),
    .abort      (abort),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .filter_row (filter_row),
    .ref_row    (ref_row),
    .busy       (busy),
    .done       (done),
    .best_idx   (best_idx),
    .best_sad   (best_sad),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  int exp_done_cyc = -1;
  int exp_cfg_cyc  = -1;
  int pend_idx = 2, pend_sad = 0;
  int exp_best_idx = 2, exp_best_sad = 0;

  logic [63:0] frows[8];
  logic [63:0] rrows[8];
  int m_sad[5];
  // Quarter-pel offset per candidate index: negative leans on the left neighbour.
  int coff[5] = '{-1, -2, 0, 2, 1};
  int order[5] = '{2, 1, 3, 0, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] mk_row(input int base, input int step);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'((base + step * i) & 255);
    return r;
  endfunction

  function automatic int pix(input logic [63:0] r, input int i);
    return int'(r[8*i +: 8]);
  endfunction

  task automatic fill(input int fb, input int fs, input int frs,
                      input int rb, input int rs, input int rrs);
    for (int k = 0; k < 8; k++) begin
      frows[k] = mk_row(fb + frs * k, fs);
      rrows[k] = mk_row(rb + rrs * k, rs);
    end
  endtask

  task automatic model_sads(input int n);
    for (int c = 0; c < 5; c++) begin
      m_sad[c] = 0;
      for (int k = 0; k < n; k++) begin
        for (int p = 1; p <= 6; p++) begin
          int w, nb, pred, d;
          w    = (coff[c] < 0) ? -coff[c] : coff[c];
          nb   = (coff[c] < 0) ? p - 1 : p + 1;
          pred = ((4 - w) * pix(rrows[k], p) + w * pix(rrows[k], nb)) / 4;
          d    = pix(frows[k], p) - pred;
          m_sad[c] += (d < 0) ? -d : d;
        end
      end
    end
  endtask

  task automatic pick_best(output int bidx, output int bsad);
    bidx = order[0];
    bsad = m_sad[order[0]];
    for (int k = 1; k < 5; k++) begin
      if (m_sad[order[k]] < bsad) begin
        bidx = order[k];
        bsad = m_sad[order[k]];
      end
    end
  endtask

  // Runs one block starting in IDLE at #1 after an edge; abort_at >= 0 aborts
  // while presenting that row index instead of completing.
  task automatic run_block(input int n, input logic [31:0] gaps, input int abort_at);
    int i, slot, bidx, bsad;
    model_sads(n);
    pick_best(bidx, bsad);
    start = 1'b1;
    num_rows = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    i = 0;
    slot = 0;
    while (i < n) begin
      if (abort_at >= 0 && i == abort_at) begin
        abort = 1'b1;
        row_valid = 1'b1;
        filter_row = frows[i];
        ref_row = rrows[i];
        @(posedge clk); #1;
        abort = 1'b0;
        row_valid = 1'b0;
        chk("busy_after_abort", busy, 0);
        chk("ready_after_abort", row_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        return;
      end
      chk("row_ready_accum", row_ready, 1);
      if (slot < 32 && gaps[slot]) begin
        row_valid = 1'b0;
      end else begin
        row_valid = 1'b1;
        filter_row = frows[i];
        ref_row = rrows[i];
        if (i == n - 1) begin
          pend_idx = bidx;
          pend_sad = bsad;
          exp_done_cyc = cyc + 7;
        end
        i++;
      end
      slot++;
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    chk("ready_after_last", row_ready, 0);
    chk("busy_in_flush", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("busy_back_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == exp_done_cyc) begin
        exp_best_idx = pend_idx;
        exp_best_sad = pend_sad;
      end
      chk("done", done, (cyc == exp_done_cyc));
      chk("cfg_err", cfg_err, (cyc == exp_cfg_cyc));
      chk("best_idx", best_idx, exp_best_idx);
      chk("best_sad", best_sad, exp_best_sad);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", row_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_best_idx", best_idx, 2);
    chk("rst_best_sad", best_sad, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Identical rows: full-pel is exact.
    fill(0, 4, 0, 0, 4, 0);
    model_sads(4);
    chk("pin34_full", m_sad[2], 0);
    chk("pin34_rq", m_sad[0], 24);
    chk("pin34_rh", m_sad[1], 48);
    run_block(4, 32'h0, -1);

    // Reference offset by +2: right half-pel is exact.
    fill(0, 4, 0, 2, 4, 0);
    model_sads(4);
    chk("pin35_rq", m_sad[0], 24);
    chk("pin35_rh", m_sad[1], 0);
    chk("pin35_full", m_sad[2], 48);
    chk("pin35_lh", m_sad[3], 96);
    chk("pin35_lq", m_sad[4], 72);
    run_block(4, 32'h0, -1);
    chk("t35_best_idx", best_idx, 1);
    chk("t35_best_sad", best_sad, 0);

    run_block(4, 32'h0000_016D, -1);
    chk("t37_best_idx", best_idx, 1);

    // Rows that differ row to row, with gaps, so a lost or repeated row shows.
    fill(10, 7, 3, 5, 9, 5);
    run_block(5, 32'h0000_0A53, -1);

    // Abort on the third row, then a clean search.
    fill(0, 4, 0, 0, 4, 0);
    run_block(4, 32'h0, 2);
    run_block(4, 32'h0, -1);
    chk("t38_best_idx", best_idx, 2);
    chk("t38_best_sad", best_sad, 0);

    // Rejected configurations and abort in IDLE.
    num_rows = 4'd0;
    start = 1'b1;
    exp_cfg_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg0_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    num_rows = 4'd9;
    start = 1'b1;
    exp_cfg_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg9_busy", busy, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;

    // Saturated pixels: all candidates tie at the maximum.
    fill(255, 0, 0, 0, 0, 0);
    model_sads(8);
    for (int c = 0; c < 5; c++) chk("pin36_sad", m_sad[c], 12240);
    run_block(8, 32'h0, -1);
    chk("t36_best_idx", best_idx, 2);
    chk("t36_best_sad", best_sad, 12240);

    // Reset mid-ACCUM overrides a simultaneous start and row.
    fill(0, 4, 0, 2, 4, 0);
    num_rows = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    row_valid = 1'b1;
    filter_row = frows[0];
    ref_row = rrows[0];
    @(posedge clk); #1;
    filter_row = frows[1];
    ref_row = rrows[1];
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    exp_best_idx = 2;
    exp_best_sad = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", row_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    start = 1'b0;
    row_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_block(4, 32'h0000_0005, -1);
    chk("recover_best_idx", best_idx, 1);
    chk("recover_best_sad", best_sad, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROWS, default 8: maximum rows per block.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin block search; sampled only in IDLE.
REQ-005 SHALL have port num_rows, input, 4 bits: rows in the block; latched on accepted start.
REQ-006 SHALL have port abort, input, 1 bit: cancel the search in progress.
REQ-007 SHALL have port row_valid, input, 1 bit: filter_row/ref_row valid.
REQ-008 SHALL have port row_ready, output, 1 bit: controller accepts a row this cycle.
REQ-009 SHALL have port filter_row, input, 64 bits: 8 filter pixels, pixel i at bits [8i+7:8i].
REQ-010 SHALL have port ref_row, input, 64 bits: 8 reference pixels, same packing.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-013 SHALL have port best_idx, output, 3 bits: winning candidate (0 RQ, 1 RH, 2 full, 3 LH, 4 LQ).
REQ-014 SHALL have port best_sad, output, 15 bits: accumulated SAD of the winner.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, FLUSH, COMPARE, DONE.
REQ-017 IDLE: start with 1<=num_rows<=MAX_ROWS SHALL latch num_rows, clear five 15-bit accumulators and the row counter, and go to ACCUM.
REQ-018 IDLE: start with num_rows==0 or >MAX_ROWS SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-019 row_ready SHALL equal 1 only in ACCUM; a row is accepted when row_valid && row_ready.
REQ-020 Accepted rows SHALL be registered into one pipeline stage; their five per-row SADs SHALL be added to the accumulators on the following edge.
REQ-021 Per-row SADs SHALL be computed with linear interpolation (truncating) over pixels 1..6, using full-width intermediates so that 255-valued inputs do not overflow.
REQ-022 The row counter SHALL increment per accepted row; acceptance of row num_rows SHALL move ACCUM->FLUSH, and row_valid gaps SHALL stall without state change.
REQ-023 FLUSH SHALL last 1 cycle, adding the last row, then go to COMPARE.
REQ-024 COMPARE SHALL last 5 cycles and visit candidates in priority order 2,1,3,0,4, replacing the running best only on strictly smaller SAD; ties therefore resolve to the higher-priority candidate.
REQ-025 DONE SHALL last 1 cycle with done=1, then go to IDLE; if the last row is accepted in cycle c, done SHALL be high in cycle c+7.
REQ-026 best_idx/best_sad SHALL update only on entry to DONE and hold until the next DONE.
REQ-027 abort in any non-IDLE state SHALL force IDLE at the next edge with no done pulse and best_* unchanged; abort SHALL take precedence over a simultaneous row acceptance.
REQ-028 start while busy SHALL be ignored; abort in IDLE SHALL have no effect.
REQ-029 Accumulators SHALL NOT wrap: the 15-bit maximum 8*6*255=12240 fits.

Reset
REQ-030 rst SHALL set state IDLE, row_ready=0, busy=0, done=0, cfg_err=0, best_idx=2, best_sad=0, and clear accumulators, counter and pipeline register.
REQ-031 rst SHALL override start, abort and row handshakes in the same cycle, including mid-search.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, candidate index constants (CAND_RQ..CAND_LQ), the priority order table, and width constants (ROW_SAD_W=12, ACC_W=15).
REQ-033 The per-row SAD datapath SHALL be the existing combinational compute_sad block, instantiated once as the sole sub-module and fed from the pipeline register.

Verification
REQ-034 Test: filter=ref=4i per pixel, num_rows=4 -> done at c+7, best_idx=2, best_sad=0.
REQ-035 Test: filter 4i, ref 4i+2, num_rows=4 -> best_idx=1 (right half exact), best_sad=0.
REQ-036 Test: filter all 0xFF, ref all 0x00, num_rows=8 -> all SADs 12240 tie, best_idx=2, best_sad=12240.
REQ-037 Test: REQ-035 stimulus with random row_valid gaps -> identical result; rows are neither lost nor double-counted.
REQ-038 Test: abort after row 2 of 4, then a fresh start with the REQ-034 stimulus -> no done for the aborted search; second search gives best_idx=2, best_sad=0.
REQ-039 Test: start with num_rows=0 and with num_rows=9 -> cfg_err pulses once each, busy stays 0; rst mid-ACCUM -> all reset values next cycle.
